// File: rtl/universal_shift_register_n_if.sv
// Interface bundling the control, data and status signals of universal_shift_register_n.
// The master side drives the controls and the parallel/serial data in; the slave side (the register) drives q and status.
// The zero flag exists only when USR_ZERO_FLAG_EN is defined.
//
// Signals:
//   enable     qualifies every register update (also stalls an active burst)
//   mode       operation select: 000 hold, 001 shl, 010 shr, 011 rotl,
//              100 rotr, 101 load, 110 asr, 111 hold
//   din        parallel load data
//   sin_r      serial bit shifted into q[0] on shl
//   sin_l      serial bit shifted into q[WIDTH-1] on shr
//   start      request a counted burst of the op selected by mode
//   burst_len  number of shifts in a burst
//   q          register contents
//   sout_l     q[WIDTH-1]
//   sout_r     q[0]
//   busy       burst in progress
//   done       one-cycle pulse when a burst completes
//   zero       (USR_ZERO_FLAG_EN only) registered "q is all zeros" flag
interface universal_shift_register_n_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             enable;
    logic [2:0]       mode;
    logic [WIDTH-1:0] din;
    logic             sin_r;
    logic             sin_l;
    logic             start;
    logic [CNT_W-1:0] burst_len;
    logic [WIDTH-1:0] q;
    logic             sout_l;
    logic             sout_r;
    logic             busy;
    logic             done;
`ifdef USR_ZERO_FLAG_EN
    logic             zero;
`endif

    modport master (
        output enable,
        output mode,
        output din,
        output sin_r,
        output sin_l,
        output start,
        output burst_len,
        input  q,
        input  sout_l,
        input  sout_r,
        input  busy,
        input  done
`ifdef USR_ZERO_FLAG_EN
        ,
        input  zero
`endif
    );

    modport slave (
        input  enable,
        input  mode,
        input  din,
        input  sin_r,
        input  sin_l,
        input  start,
        input  burst_len,
        output q,
        output sout_l,
        output sout_r,
        output busy,
        output done
`ifdef USR_ZERO_FLAG_EN
        ,
        output zero
`endif
    );
endinterface

// File: rtl/universal_shift_register_n.sv
// N-bit universal shift register (hold/shl/shr/rotl/rotr/asr/load) with a counted burst-shift engine.
// Latency: single ops update q on the enabled edge; a burst accepted at edge N shifts on edges N+1..N+L and done is high after edge N+L.
// Backpressure: enable low freezes q and the burst count; mode, din, start and burst_len are ignored while busy.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset (q <= RESET_VAL, FSM to IDLE)
//   bus    slave side of universal_shift_register_n_if (controls, data, q, status)
//
// Optional feature: define USR_ZERO_FLAG_EN to add the registered zero flag,
// which tracks "next-state q is all zeros" and therefore follows q exactly.
//
// Parameter legality: WIDTH >= 2, and 2**CNT_W > WIDTH so a full-width burst
// length is representable.
module universal_shift_register_n #(
    parameter int               WIDTH     = 8,
    parameter int               CNT_W     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    universal_shift_register_n_if.slave  bus
);

    // Operation codes carried on mode.
    localparam logic [2:0] OP_HOLD  = 3'b000;
    localparam logic [2:0] OP_SHL   = 3'b001;
    localparam logic [2:0] OP_SHR   = 3'b010;
    localparam logic [2:0] OP_ROTL  = 3'b011;
    localparam logic [2:0] OP_ROTR  = 3'b100;
    localparam logic [2:0] OP_LOAD  = 3'b101;
    localparam logic [2:0] OP_ASR   = 3'b110;
    localparam logic [2:0] OP_HOLD2 = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;     // shifts still to perform in the burst
    logic [2:0]       op_q,    op_d;      // op latched at burst acceptance
    logic [WIDTH-1:0] q_q,     q_d;
    logic             done_q,  done_d;

    // Only shift/rotate codes may start a burst; load and hold never do.
    function automatic logic is_shift_op(input logic [2:0] op);
        logic r;
        r = 1'b0;
        case (op)
            OP_SHL, OP_SHR, OP_ROTL, OP_ROTR, OP_ASR: r = 1'b1;
            default:                                  r = 1'b0;
        endcase
        return r;
    endfunction

    // One step of the selected operation applied to value v.
    function automatic logic [WIDTH-1:0] apply_op(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] v,
        input logic             s_r,
        input logic             s_l,
        input logic [WIDTH-1:0] ld
    );
        logic [WIDTH-1:0] r;
        r = v;
        case (op)
            OP_SHL:   r = {v[WIDTH-2:0], s_r};
            OP_SHR:   r = {s_l, v[WIDTH-1:1]};
            OP_ROTL:  r = {v[WIDTH-2:0], v[WIDTH-1]};
            OP_ROTR:  r = {v[0], v[WIDTH-1:1]};
            OP_LOAD:  r = ld;
            OP_ASR:   r = {v[WIDTH-1], v[WIDTH-1:1]};
            OP_HOLD,
            OP_HOLD2: r = v;
            default:  r = v;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        q_d     = q_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start && is_shift_op(bus.mode)) begin
                    // Acceptance does not need enable and never shifts on
                    // this edge; a zero-length burst just reports done.
                    if (bus.burst_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        op_d    = bus.mode;
                        cnt_d   = bus.burst_len;
                        state_d = ST_BUSY;
                    end
                end else if (bus.enable) begin
                    q_d = apply_op(bus.mode, q_q, bus.sin_r, bus.sin_l, bus.din);
                end
            end

            ST_BUSY: begin
                // Serial inputs stay live during a burst; only the op and the
                // length are frozen at acceptance.
                if (bus.enable) begin
                    q_d   = apply_op(op_q, q_q, bus.sin_r, bus.sin_l, bus.din);
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_HOLD;
            q_q     <= RESET_VAL;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            q_q     <= q_d;
            done_q  <= done_d;
        end
    end

`ifdef USR_ZERO_FLAG_EN
    // Registered from q_d so the flag changes on the same edge as q.
    logic zero_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zero_q <= (RESET_VAL == '0);
        end else begin
            zero_q <= (q_d == '0);
        end
    end

    assign bus.zero = zero_q;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.q      = q_q;
    assign bus.sout_l = q_q[WIDTH-1];
    assign bus.sout_r = q_q[0];
    assign bus.busy   = (state_q == ST_BUSY);
    assign bus.done   = done_q;

endmodule

// File: tb/tb_universal_shift_register_n.sv
module tb_universal_shift_register_n;
    localparam logic [7:0] RV = 8'hA5;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    universal_shift_register_n_if #(.WIDTH(8), .CNT_W(4)) bus ();

    universal_shift_register_n #(
        .WIDTH    (8),
        .CNT_W    (4),
        .RESET_VAL(RV)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    bit run_cmp = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: q as an integer 0..255, ops as arithmetic.
    // ------------------------------------------------------------------
    int m_q    = int'(RV);
    int m_left = 0;
    int m_op   = 0;
    bit m_busy = 1'b0;
    bit m_done = 1'b0;
    bit m_nd   = 1'b0;

    function automatic int model_op(input int op, input int v, input int sr, input int sl, input int d);
        case (op)
            1:       return ((v * 2) % 256) + sr;
            2:       return (v / 2) + sl * 128;
            3:       return ((v * 2) % 256) + (v / 128);
            4:       return (v / 2) + (v % 2) * 128;
            5:       return d;
            6:       return (v / 2) + (v / 128) * 128;
            default: return v;
        endcase
    endfunction

    function automatic bit model_is_shift(input int op);
        return (op >= 1 && op <= 4) || op == 6;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q    = int'(RV);
            m_busy = 1'b0;
            m_done = 1'b0;
            m_left = 0;
        end else begin
            m_nd = 1'b0;
            if (!m_busy) begin
                if (bus.start && model_is_shift(int'(bus.mode))) begin
                    if (bus.burst_len == 0) m_nd = 1'b1;
                    else begin
                        m_busy = 1'b1;
                        m_left = int'(bus.burst_len);
                        m_op   = int'(bus.mode);
                    end
                end else if (bus.enable) begin
                    m_q = model_op(int'(bus.mode), m_q, int'(bus.sin_r), int'(bus.sin_l), int'(bus.din));
                end
            end else if (bus.enable) begin
                m_q = model_op(m_op, m_q, int'(bus.sin_r), int'(bus.sin_l), int'(bus.din));
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_nd   = 1'b1;
                end
            end
            m_done = m_nd;
        end
    end

    // Cycle-by-cycle compare, away from the active edge.
    always @(negedge clk) begin
        if (run_cmp) begin
            chk("cmp_q",      32'(bus.q),      32'(m_q));
            chk("cmp_sout_l", 32'(bus.sout_l), 32'(m_q / 128));
            chk("cmp_sout_r", 32'(bus.sout_r), 32'(m_q % 2));
            chk("cmp_busy",   32'(bus.busy),   32'(m_busy));
            chk("cmp_done",   32'(bus.done),   32'(m_done));
`ifdef USR_ZERO_FLAG_EN
            chk("cmp_zero",   32'(bus.zero),   32'(m_q == 0));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] md, input logic en, input logic st,
                         input logic [3:0] bl, input logic [7:0] d,
                         input logic sr, input logic sl);
        bus.mode      = md;
        bus.enable    = en;
        bus.start     = st;
        bus.burst_len = bl;
        bus.din       = d;
        bus.sin_r     = sr;
        bus.sin_l     = sl;
    endtask

    int busy_cnt;
    int done_cnt;
    int done_at;
    logic       en_v [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [2:0] md_v [6] = '{3'd2, 3'd5, 3'd0, 3'd7, 3'd1, 3'd6};

    initial begin
        drive(3'd0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
        #1 reset = 1'b1;
        #1;
        run_cmp = 1'b1;
        chk("reset_q",    32'(bus.q),    32'hA5);
        chk("reset_busy", 32'(bus.busy), 32'h0);
        chk("reset_done", 32'(bus.done), 32'h0);
        tick();
        tick();
        reset = 1'b0;

        // load / rotate
        drive(3'd5, 1'b1, 1'b0, 4'd0, 8'h81, 1'b0, 1'b0); tick();
        chk("load_81", 32'(bus.q), 32'h81);
        drive(3'd3, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0); tick();
        chk("rotl_03", 32'(bus.q), 32'h03);
        drive(3'd4, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0); tick(); tick();
        chk("rotr2_c0",  32'(bus.q),      32'hC0);
        chk("c0_sout_l", 32'(bus.sout_l), 32'h1);
        chk("c0_sout_r", 32'(bus.sout_r), 32'h0);

        // asr / shr / shl
        drive(3'd5, 1'b1, 1'b0, 4'd0, 8'h90, 1'b0, 1'b0); tick();
        drive(3'd6, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0); tick();
        chk("asr_c8", 32'(bus.q), 32'hC8);
        drive(3'd2, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0); tick();
        chk("shr_64", 32'(bus.q), 32'h64);
        drive(3'd1, 1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0); tick();
        chk("shl_c9", 32'(bus.q), 32'hC9);

        // hold with enable low and mode 111
        drive(3'd7, 1'b1, 1'b0, 4'd0, 8'hFF, 1'b1, 1'b1); tick();
        chk("hold7_c9", 32'(bus.q), 32'hC9);
        drive(3'd1, 1'b0, 1'b0, 4'd0, 8'hFF, 1'b1, 1'b1); tick();
        chk("en0_c9", 32'(bus.q), 32'hC9);

        // burst shl x3 from 01
        drive(3'd5, 1'b1, 1'b0, 4'd0, 8'h01, 1'b0, 1'b0); tick();
        drive(3'd1, 1'b1, 1'b1, 4'd3, 8'h00, 1'b0, 1'b0); tick();
        chk("shl3_accept_q",    32'(bus.q),    32'h01);
        chk("shl3_accept_busy", 32'(bus.busy), 32'h1);
        busy_cnt = 1;
        done_cnt = 0;
        drive(3'd0, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                chk("shl3_done_q", 32'(bus.q), 32'h08);
            end
        end
        chk("shl3_busy_cycles", 32'(busy_cnt), 32'd3);
        chk("shl3_done_count",  32'(done_cnt), 32'd1);
        chk("shl3_final_q",     32'(bus.q),    32'h08);

        // burst rotl x4 from 12 with 2 stall cycles and mode/start churn
        drive(3'd5, 1'b1, 1'b0, 4'd0, 8'h12, 1'b0, 1'b0); tick();
        drive(3'd3, 1'b0, 1'b1, 4'd4, 8'hFF, 1'b1, 1'b1); tick();
        chk("rotl4_accept_busy", 32'(bus.busy), 32'h1);
        done_at  = 0;
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            drive(md_v[i], en_v[i], 1'b1, 4'd9, 8'hFF, 1'b1, 1'b1);
            tick();
            if (bus.done) begin
                done_cnt++;
                done_at = i + 1;
            end
        end
        chk("rotl4_done_cycle", 32'(done_at),  32'd6);
        chk("rotl4_done_count", 32'(done_cnt), 32'd1);
        chk("rotl4_q_21",       32'(bus.q),    32'h21);

        // zero-length burst
        drive(3'd1, 1'b1, 1'b1, 4'd0, 8'h00, 1'b1, 1'b0); tick();
        chk("len0_done", 32'(bus.done), 32'h1);
        chk("len0_q",    32'(bus.q),    32'h21);
        chk("len0_busy", 32'(bus.busy), 32'h0);
        drive(3'd0, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0); tick();
        chk("len0_done_clr", 32'(bus.done), 32'h0);

        // start with load: ignored, op executes, no done
        drive(3'd5, 1'b1, 1'b1, 4'd3, 8'h5A, 1'b0, 1'b0); tick();
        chk("start_load_q",    32'(bus.q),    32'h5A);
        chk("start_load_busy", 32'(bus.busy), 32'h0);
        tick();
        chk("start_load_done", 32'(bus.done), 32'h0);

`ifdef USR_ZERO_FLAG_EN
        drive(3'd5, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0); tick();
        chk("zero_set", 32'(bus.zero), 32'h1);
        drive(3'd1, 1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0); tick();
        chk("zero_clr", 32'(bus.zero), 32'h0);
        chk("zero_q01", 32'(bus.q),    32'h01);
`endif

        // reset mid-burst
        drive(3'd5, 1'b1, 1'b0, 4'd0, 8'h3C, 1'b0, 1'b0); tick();
        drive(3'd4, 1'b1, 1'b1, 4'd5, 8'h00, 1'b0, 1'b0); tick();
        drive(3'd0, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0); tick();
        chk("midburst_q_1e", 32'(bus.q), 32'h1E);
        #2 reset = 1'b1;
        #1;
        chk("arst_q",    32'(bus.q),    32'hA5);
        chk("arst_busy", 32'(bus.busy), 32'h0);
        chk("arst_done", 32'(bus.done), 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.done) done_cnt++;
        end
        chk("post_arst_no_done", 32'(done_cnt), 32'd0);
        chk("post_arst_q",       32'(bus.q),    32'hA5);

        run_cmp = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
